param_register_stack: RTL and testbench
=======================================

Name: param_register_stack

Overview:
- Parametrised successor to the processor's data stack. Holds a DEPTH-entry, WIDTH-bit LIFO of registers.
- Top two entries are exposed combinationally to feed the ALU.
- Adds occupancy tracking, full/empty status, sticky overflow/underflow error flags, and DUP/OVER/SWAP/POP_REPLACE ops that the processor core needs for the next ISA revision.

Parameters:
- WIDTH, 16, data width of each entry and of w/a/b.
- DEPTH, 16, number of entries (>=2).
- CNT_W, $clog2(DEPTH+1), width of the count output (localparam, derived).

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- stackOP  input  3  operation select, sampled each rising edge
- w  input  WIDTH  write data for PUSH/REPLACE/POP_REPLACE
- clr_err  input  1  synchronous clear of sticky error flags
- a  output  WIDTH  top of stack, combinational
- b  output  WIDTH  second of stack, combinational
- count  output  CNT_W  current number of valid entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky; set by an op that would exceed DEPTH
- underflow  output  1  sticky; set by an op needing more entries than are valid

Behaviour:
- Reset (async, any time, including mid-operation): all entries = 0, count = 0, overflow = 0, underflow = 0. Therefore a = 0, b = 0, empty = 1, full = 0.
- Storage: entries[0..DEPTH-1], with the top at index count-1.
  - a = entries[count-1] if count >= 1, else 0.
  - b = entries[count-2] if count >= 2, else 0.
- Latency: an op sampled at edge N is visible on a/b/count after edge N (same cycle the registers update). No handshake; one op per cycle.
- stackOP encoding, with the required count (need) and space (room) for each:
  - 0 NOP: no change.
  - 1 PUSH: need 0, room 1. Pushes w; count+1.
  - 2 POP: need 1. count-1.
  - 3 REPLACE: need 1. Top = w; count unchanged.
  - 4 POP_REPLACE: need 2. Discards top; new top (old b slot) = w; count-1. Used for binary ALU results.
  - 5 SWAP: need 2. Exchanges a and b.
  - 6 DUP: need 1, room 1. Pushes a copy of a.
  - 7 OVER: need 2, room 1. Pushes a copy of b.
- Illegal-op handling:
  - If count < need: the op is suppressed entirely (no entry or count change) and underflow is set.
  - If room is required and count == DEPTH: the op is suppressed and overflow is set.
  - The two conditions are mutually exclusive per op.
- Popped entries are not cleared; they are only overwritten by later pushes.
- Sticky flags:
  - Once set, overflow and underflow stay high until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the new error wins: the flag ends the cycle high.
- Wrap-around: none. count saturates via suppression and never exceeds DEPTH or goes below 0.
- full and empty are derived combinationally from count.

Optional Feature:
- Macro: PARAM_REGISTER_STACK_PEEK_EN.
- With the macro defined, two extra ports are added:
  - peek_idx  input  CNT_W: depth index, 0 = top.
  - peek_data  output  WIDTH: combinational; equals entries[count-1-peek_idx] when peek_idx < count, else 0. Intended for debug display of the stack.
- Without the macro, neither port exists and no read mux is synthesised. Core behaviour is identical in both builds.

Test Plan:
- Reset then PUSH 0x0011, PUSH 0x0022 -> a=0x0022, b=0x0011, count=2, empty=0; SWAP -> a=0x0011, b=0x0022.
- From count=2 (a=0x0005, b=0x0003), POP_REPLACE with w=0x0008 -> count=1, a=0x0008, b=0, no error flags.
- DEPTH=16: PUSH 16 values 0x0001..0x0010 -> full=1, a=0x0010; 17th PUSH 0xFFFF -> a=0x0010, count=16, overflow=1; clr_err -> overflow=0.
- Empty stack: POP -> count=0, underflow=1; then SWAP with count=1 -> suppressed, underflow stays 1; clr_err together with another POP on empty -> underflow=1.
- count=2 (a=0x00AA, b=0x00BB): DUP -> a=0x00AA, b=0x00AA, count=3; OVER -> a=0x00AA, count=4; REPLACE w=0x1234 -> a=0x1234.
- Assert reset mid-sequence with count=5 and overflow=1, asynchronously between edges -> count=0, a=0, b=0, flags=0 immediately. With PEEK_EN: after PUSH 1,2,3, peek_idx=2 -> 1; peek_idx=3 -> 0.

Source files
------------

// File: rtl/param_register_stack.sv
// -----------------------------------------------------------------------------
// param_register_stack
//
// Parametrised LIFO register stack feeding the ALU. The top two entries are
// presented combinationally on a/b. Occupancy is tracked in count, full/empty
// are decoded from it, and illegal operations are suppressed while raising
// sticky overflow/underflow flags.
//
// Parameters:
//   WIDTH  data width of each entry and of w/a/b
//   DEPTH  number of entries (>= 2)
//   CNT_W  width of count, derived as $clog2(DEPTH+1)
//
// Ports:
//   CLK        system clock, rising edge
//   reset      asynchronous active-high reset, clears all state
//   stackOP    operation select: 0 NOP, 1 PUSH, 2 POP, 3 REPLACE,
//              4 POP_REPLACE, 5 SWAP, 6 DUP, 7 OVER
//   w          write data for PUSH/REPLACE/POP_REPLACE
//   clr_err    synchronous clear of the sticky error flags
//   a          top of stack (0 when empty)
//   b          second of stack (0 when fewer than two entries)
//   count      number of valid entries
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: an op needed room while the stack was full
//   underflow  sticky: an op needed more entries than were valid
//
// Optional feature (macro PARAM_REGISTER_STACK_PEEK_EN):
//   peek_idx   depth index into the stack, 0 = top
//   peek_data  entry at that depth, or 0 when peek_idx >= count
// -----------------------------------------------------------------------------
module param_register_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [2:0]       stackOP,
    input  logic [WIDTH-1:0] w,
    input  logic             clr_err,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
`ifdef PARAM_REGISTER_STACK_PEEK_EN
    ,
    input  logic [CNT_W-1:0] peek_idx,
    output logic [WIDTH-1:0] peek_data
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] OP_NOP         = 3'd0;
    localparam logic [2:0] OP_PUSH        = 3'd1;
    localparam logic [2:0] OP_POP         = 3'd2;
    localparam logic [2:0] OP_REPLACE     = 3'd3;
    localparam logic [2:0] OP_POP_REPLACE = 3'd4;
    localparam logic [2:0] OP_SWAP        = 3'd5;
    localparam logic [2:0] OP_DUP         = 3'd6;
    localparam logic [2:0] OP_OVER        = 3'd7;

    logic [WIDTH-1:0] entries_r [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             underflow_r;

    logic [IDX_W-1:0] top_idx_s;
    logic [IDX_W-1:0] sec_idx_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [1:0]       need_s;
    logic             room_s;
    logic             under_s;
    logic             over_s;
    logic             exec_s;

    // Slot indices; only meaningful when the op's entry requirement is met,
    // otherwise the op is suppressed and the wrapped value is never used.
    always_comb begin
        top_idx_s  = IDX_W'(count_r - CNT_W'(1));
        sec_idx_s  = IDX_W'(count_r - CNT_W'(2));
        push_idx_s = IDX_W'(count_r);
    end

    // Per-op entry requirement (need) and space requirement (room).
    always_comb begin
        need_s = 2'd0;
        room_s = 1'b0;
        case (stackOP)
            OP_NOP:         begin need_s = 2'd0; room_s = 1'b0; end
            OP_PUSH:        begin need_s = 2'd0; room_s = 1'b1; end
            OP_POP:         begin need_s = 2'd1; room_s = 1'b0; end
            OP_REPLACE:     begin need_s = 2'd1; room_s = 1'b0; end
            OP_POP_REPLACE: begin need_s = 2'd2; room_s = 1'b0; end
            OP_SWAP:        begin need_s = 2'd2; room_s = 1'b0; end
            OP_DUP:         begin need_s = 2'd1; room_s = 1'b1; end
            OP_OVER:        begin need_s = 2'd2; room_s = 1'b1; end
            default:        begin need_s = 2'd0; room_s = 1'b0; end
        endcase
    end

    // Legality: underflow and overflow are mutually exclusive because every
    // op that needs room has need <= 2 <= DEPTH.
    always_comb begin
        under_s = (count_r < CNT_W'(need_s));
        if (!under_s && room_s && (count_r == CNT_W'(DEPTH))) begin
            over_s = 1'b1;
        end else begin
            over_s = 1'b0;
        end
        exec_s = !under_s && !over_s;
    end

    // Stack storage and occupancy. Popped slots keep stale data.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= {WIDTH{1'b0}};
            end
            count_r <= {CNT_W{1'b0}};
        end else if (exec_s) begin
            case (stackOP)
                OP_NOP: begin
                    count_r <= count_r;
                end
                OP_PUSH: begin
                    entries_r[push_idx_s] <= w;
                    count_r               <= count_r + CNT_W'(1);
                end
                OP_POP: begin
                    count_r <= count_r - CNT_W'(1);
                end
                OP_REPLACE: begin
                    entries_r[top_idx_s] <= w;
                end
                OP_POP_REPLACE: begin
                    entries_r[sec_idx_s] <= w;
                    count_r              <= count_r - CNT_W'(1);
                end
                OP_SWAP: begin
                    entries_r[top_idx_s] <= entries_r[sec_idx_s];
                    entries_r[sec_idx_s] <= entries_r[top_idx_s];
                end
                OP_DUP: begin
                    entries_r[push_idx_s] <= entries_r[top_idx_s];
                    count_r               <= count_r + CNT_W'(1);
                end
                OP_OVER: begin
                    entries_r[push_idx_s] <= entries_r[sec_idx_s];
                    count_r               <= count_r + CNT_W'(1);
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err wins.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (over_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (under_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    // Top-of-stack read ports for the ALU.
    always_comb begin
        if (count_r >= CNT_W'(1)) begin
            a = entries_r[top_idx_s];
        end else begin
            a = {WIDTH{1'b0}};
        end
        if (count_r >= CNT_W'(2)) begin
            b = entries_r[sec_idx_s];
        end else begin
            b = {WIDTH{1'b0}};
        end
    end

    assign count     = count_r;
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

`ifdef PARAM_REGISTER_STACK_PEEK_EN
    logic [CNT_W-1:0] peek_pos_s;

    // Debug read mux: depth 0 is the top entry.
    always_comb begin
        peek_pos_s = count_r - CNT_W'(1) - peek_idx;
        if (peek_idx < count_r) begin
            peek_data = entries_r[IDX_W'(peek_pos_s)];
        end else begin
            peek_data = {WIDTH{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_param_register_stack.sv
module tb_param_register_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             CLK;
    logic             reset;
    logic [2:0]       stackOP;
    logic [WIDTH-1:0] w;
    logic             clr_err;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
`ifdef PARAM_REGISTER_STACK_PEEK_EN
    logic [CNT_W-1:0] peek_idx;
    logic [WIDTH-1:0] peek_data;
`endif

    int tests;
    int fails;

    // Reference model: queue with the top at the back, plus sticky flags.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    bit               m_unf;

    param_register_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .stackOP   (stackOP),
        .w         (w),
        .clr_err   (clr_err),
        .a         (a),
        .b         (b),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef PARAM_REGISTER_STACK_PEEK_EN
        ,
        .peek_idx  (peek_idx),
        .peek_data (peek_data)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [WIDTH-1:0] m_a();
        if (q.size() >= 1) return q[q.size()-1];
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_b();
        if (q.size() >= 2) return q[q.size()-2];
        return '0;
    endfunction

    // Drive one op for one clock and advance the model with it.
    task automatic apply(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic c);
        int need;
        bit room;
        logic [WIDTH-1:0] t;
        @(negedge CLK);
        stackOP = op;
        w       = d;
        clr_err = c;
        @(posedge CLK);
        case (op)
            3'd1: begin need = 0; room = 1; end
            3'd2: begin need = 1; room = 0; end
            3'd3: begin need = 1; room = 0; end
            3'd4: begin need = 2; room = 0; end
            3'd5: begin need = 2; room = 0; end
            3'd6: begin need = 1; room = 1; end
            3'd7: begin need = 2; room = 1; end
            default: begin need = 0; room = 0; end
        endcase
        if (c) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (q.size() < need) begin
            m_unf = 1;
        end else if (room && q.size() == DEPTH) begin
            m_ovf = 1;
        end else begin
            case (op)
                3'd1: q.push_back(d);
                3'd2: void'(q.pop_back());
                3'd3: q[q.size()-1] = d;
                3'd4: begin void'(q.pop_back()); q[q.size()-1] = d; end
                3'd5: begin
                    t = q[q.size()-1];
                    q[q.size()-1] = q[q.size()-2];
                    q[q.size()-2] = t;
                end
                3'd6: begin t = q[q.size()-1]; q.push_back(t); end
                3'd7: begin t = q[q.size()-2]; q.push_back(t); end
                default: ;
            endcase
        end
        #1;
        stackOP = 3'd0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #2;
        reset = 1'b0;
        q.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (a !== 16'h0000) begin fails++; $display("FAIL reset_a got %h exp 0000", a); end
        tests++; if (b !== 16'h0000) begin fails++; $display("FAIL reset_b got %h exp 0000", b); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
        tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
    endtask

    task automatic test_push_swap();
        do_reset();
        apply(3'd1, 16'h0011, 1'b0);
        apply(3'd1, 16'h0022, 1'b0);
        tests++; if (a !== 16'h0022 || b !== 16'h0011) begin fails++; $display("FAIL push_ab got %h/%h exp 0022/0011", a, b); end
        tests++; if (count !== 5'd2 || empty !== 1'b0) begin fails++; $display("FAIL push_count got %0d empty %b exp 2 0", count, empty); end
        apply(3'd5, 16'h0000, 1'b0);
        tests++; if (a !== 16'h0011 || b !== 16'h0022) begin fails++; $display("FAIL swap_ab got %h/%h exp 0011/0022", a, b); end
    endtask

    task automatic test_pop_replace();
        do_reset();
        apply(3'd1, 16'h0003, 1'b0);
        apply(3'd1, 16'h0005, 1'b0);
        apply(3'd4, 16'h0008, 1'b0);
        tests++; if (count !== 5'd1 || a !== 16'h0008 || b !== 16'h0000) begin fails++; $display("FAIL pop_replace got cnt %0d a %h b %h exp 1 0008 0000", count, a, b); end
        tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL pop_replace_flags got %b%b exp 00", overflow, underflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) apply(3'd1, 16'(i), 1'b0);
        tests++; if (full !== 1'b1 || a !== 16'h0010 || b !== 16'h000F) begin fails++; $display("FAIL fill got full %b a %h b %h exp 1 0010 000f", full, a, b); end
        apply(3'd1, 16'hFFFF, 1'b0);
        tests++; if (a !== 16'h0010 || count !== 5'd16 || overflow !== 1'b1) begin fails++; $display("FAIL overflow got a %h cnt %0d ovf %b exp 0010 16 1", a, count, overflow); end
        apply(3'd6, 16'h0000, 1'b0);
        tests++; if (count !== 5'd16 || underflow !== 1'b0) begin fails++; $display("FAIL dup_full got cnt %0d unf %b exp 16 0", count, underflow); end
        apply(3'd0, 16'h0000, 1'b1);
        tests++; if (overflow !== 1'b0 || count !== 5'd16) begin fails++; $display("FAIL clr_ovf got ovf %b cnt %0d exp 0 16", overflow, count); end
    endtask

    task automatic test_underflow();
        do_reset();
        apply(3'd2, 16'h0000, 1'b0);
        tests++; if (count !== 5'd0 || underflow !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL pop_empty got cnt %0d unf %b ovf %b exp 0 1 0", count, underflow, overflow); end
        apply(3'd1, 16'h0042, 1'b0);
        apply(3'd5, 16'h0000, 1'b0);
        tests++; if (count !== 5'd1 || a !== 16'h0042 || underflow !== 1'b1) begin fails++; $display("FAIL swap_one got cnt %0d a %h unf %b exp 1 0042 1", count, a, underflow); end
        apply(3'd2, 16'h0000, 1'b0);
        apply(3'd2, 16'h0000, 1'b1);
        tests++; if (underflow !== 1'b1 || count !== 5'd0) begin fails++; $display("FAIL clr_vs_err got unf %b cnt %0d exp 1 0", underflow, count); end
        apply(3'd0, 16'h0000, 1'b1);
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL clr_unf got %b exp 0", underflow); end
    endtask

    task automatic test_dup_over();
        do_reset();
        apply(3'd1, 16'h00BB, 1'b0);
        apply(3'd1, 16'h00AA, 1'b0);
        apply(3'd6, 16'h0000, 1'b0);
        tests++; if (a !== 16'h00AA || b !== 16'h00AA || count !== 5'd3) begin fails++; $display("FAIL dup got a %h b %h cnt %0d exp 00aa 00aa 3", a, b, count); end
        apply(3'd7, 16'h0000, 1'b0);
        tests++; if (a !== 16'h00AA || count !== 5'd4) begin fails++; $display("FAIL over got a %h cnt %0d exp 00aa 4", a, count); end
        apply(3'd3, 16'h1234, 1'b0);
        tests++; if (a !== 16'h1234 || b !== 16'h00AA || count !== 5'd4) begin fails++; $display("FAIL replace got a %h b %h cnt %0d exp 1234 00aa 4", a, b, count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) apply(3'd1, 16'(i + 100), 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) apply(3'd2, 16'h0000, 1'b0);
        tests++; if (count !== 5'd5 || overflow !== 1'b1) begin fails++; $display("FAIL areset_pre got cnt %0d ovf %b exp 5 1", count, overflow); end
        @(negedge CLK);
        #2;
        reset = 1'b1;
        #1;
        tests++; if (count !== 5'd0 || a !== 16'h0000 || b !== 16'h0000) begin fails++; $display("FAIL areset got cnt %0d a %h b %h exp 0 0000 0000", count, a, b); end
        tests++; if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL areset_flags got %b%b empty %b exp 00 1", overflow, underflow, empty); end
        #1;
        reset = 1'b0;
        q.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

`ifdef PARAM_REGISTER_STACK_PEEK_EN
    task automatic test_peek();
        do_reset();
        apply(3'd1, 16'h0001, 1'b0);
        apply(3'd1, 16'h0002, 1'b0);
        apply(3'd1, 16'h0003, 1'b0);
        peek_idx = 5'd2;
        #1;
        tests++; if (peek_data !== 16'h0001) begin fails++; $display("FAIL peek2 got %h exp 0001", peek_data); end
        peek_idx = 5'd3;
        #1;
        tests++; if (peek_data !== 16'h0000) begin fails++; $display("FAIL peek3 got %h exp 0000", peek_data); end
        peek_idx = 5'd0;
    endtask
`endif

    task automatic test_random();
        logic [2:0] op;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n < 250 && $urandom_range(0, 2) != 0) op = 3'd1;
            else if (n >= 450 && $urandom_range(0, 2) != 0) op = 3'd2;
            else op = 3'($urandom_range(0, 7));
            apply(op, 16'($urandom), ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
            tests++; if (count !== 5'(q.size())) begin fails++; $display("FAIL rnd_count n=%0d op=%0d got %0d exp %0d", n, op, count, q.size()); end
            tests++; if (a !== m_a()) begin fails++; $display("FAIL rnd_a n=%0d op=%0d got %h exp %h", n, op, a, m_a()); end
            tests++; if (b !== m_b()) begin fails++; $display("FAIL rnd_b n=%0d op=%0d got %h exp %h", n, op, b, m_b()); end
            tests++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin fails++; $display("FAIL rnd_full_empty n=%0d got %b%b exp %b%b", n, full, empty, q.size() == DEPTH, q.size() == 0); end
            tests++; if (overflow !== m_ovf || underflow !== m_unf) begin fails++; $display("FAIL rnd_flags n=%0d op=%0d got %b%b exp %b%b", n, op, overflow, underflow, m_ovf, m_unf); end
`ifdef PARAM_REGISTER_STACK_PEEK_EN
            peek_idx = 5'($urandom_range(0, DEPTH));
            #1;
            tests++;
            if (peek_data !== ((peek_idx < q.size()) ? q[q.size()-1-peek_idx] : 16'h0000)) begin
                fails++; $display("FAIL rnd_peek n=%0d idx %0d got %h", n, peek_idx, peek_data);
            end
`endif
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        stackOP = 3'd0;
        w       = 16'h0000;
        clr_err = 1'b0;
`ifdef PARAM_REGISTER_STACK_PEEK_EN
        peek_idx = 5'd0;
`endif
        test_reset();
        test_push_swap();
        test_pop_replace();
        test_overflow();
        test_underflow();
        test_dup_over();
        test_async_reset();
`ifdef PARAM_REGISTER_STACK_PEEK_EN
        test_peek();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
